// File: rtl/tft_cmd_pkg.sv
// Shared definitions for the TFT SPI receiver: command codes, parser states
// and RGB565 field widths.
package tft_cmd_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam int RED_W   = 5;
    localparam int GREEN_W = 6;
    localparam int BLUE_W  = 5;
    localparam int PIXEL_W = RED_W + GREEN_W + BLUE_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET,
        ST_PASET,
        ST_RAMWR_HI,
        ST_RAMWR_LO,
        ST_SKIP
    } parser_state_t;

endpackage

// File: rtl/tft_spi_receiver_if.sv
// Bus bundle between a TFT SPI source/monitor (master) and the receiver (slave).
interface tft_spi_receiver_if #(
    parameter int COORD_W = 9
);
    logic               tft_clk;
    logic               tft_mosi;
    logic               tft_dc;
    logic               tft_cs;
    logic               byte_valid;
    logic [7:0]         byte_data;
    logic               byte_dc;
    logic               cmd_valid;
    logic [7:0]         cmd_code;
    logic               pixel_valid;
    logic [COORD_W-1:0] pixel_x;
    logic [COORD_W-1:0] pixel_y;
    logic [15:0]        pixel_color;
    logic               frame_done;

    modport master (
        output tft_clk, tft_mosi, tft_dc, tft_cs,
        input  byte_valid, byte_data, byte_dc, cmd_valid, cmd_code,
        input  pixel_valid, pixel_x, pixel_y, pixel_color, frame_done
    );

    modport slave (
        input  tft_clk, tft_mosi, tft_dc, tft_cs,
        output byte_valid, byte_data, byte_dc, cmd_valid, cmd_code,
        output pixel_valid, pixel_x, pixel_y, pixel_color, frame_done
    );
endinterface

// File: rtl/spi_byte_deserializer.sv
// Brings the asynchronous SPI pins into the clk domain and assembles MSB-first
// bytes on each rising edge of the synchronised SPI clock (mode 0).
module spi_byte_deserializer #(
    parameter int USE_CS = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tftClk,
    input  logic       i_tftMosi,
    input  logic       i_tftDc,
    input  logic       i_tftCs,
    output logic       o_byteValid,
    output logic [7:0] o_byteData,
    output logic       o_byteDc
);

    logic [2:0] r_clkSync;
    logic [1:0] r_mosiSync;
    logic [1:0] r_dcSync;
    logic [1:0] r_csSync;
    logic [2:0] r_bitCnt;
    logic [6:0] r_shift;
    logic       r_byteValid;
    logic [7:0] r_byteData;
    logic       r_byteDc;
    logic       w_rise;
    logic       w_csActive;

    // Synchronisers are left unreset so a high tft_clk at reset release cannot fake an edge.
    always_ff @(posedge clk) begin
        r_clkSync  <= {r_clkSync[1:0], i_tftClk};
        r_mosiSync <= {r_mosiSync[0], i_tftMosi};
        r_dcSync   <= {r_dcSync[0], i_tftDc};
        r_csSync   <= {r_csSync[0], i_tftCs};
    end

    assign w_rise     = r_clkSync[1] & ~r_clkSync[2];
    assign w_csActive = (USE_CS == 0) || !r_csSync[1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bitCnt    <= 3'd0;
            r_shift     <= 7'd0;
            r_byteValid <= 1'b0;
            r_byteData  <= 8'd0;
            r_byteDc    <= 1'b0;
        end else begin
            r_byteValid <= 1'b0;
            if (!w_csActive) begin
                r_bitCnt <= 3'd0;
            end else if (w_rise) begin
                r_shift  <= {r_shift[5:0], r_mosiSync[1]};
                r_bitCnt <= r_bitCnt + 3'd1;
                if (r_bitCnt == 3'd7) begin
                    r_byteValid <= 1'b1;
                    r_byteData  <= {r_shift, r_mosiSync[1]};
                    r_byteDc    <= r_dcSync[1];
                end
            end
        end
    end

    assign o_byteValid = r_byteValid;
    assign o_byteData  = r_byteData;
    assign o_byteDc    = r_byteDc;

endmodule

// File: rtl/tft_spi_receiver.sv
// Decodes the received byte stream (CASET/PASET/RAMWR) into windowed RGB565
// pixel writes; command/pixel strobes coincide with the byte strobe.
module tft_spi_receiver
    import tft_cmd_pkg::*;
#(
    parameter int WIDTH   = 240,
    parameter int HEIGHT  = 320,
    parameter int COORD_W = 9,
    parameter int USE_CS  = 0
) (
    input logic               clk,
    input logic               rst,
    tft_spi_receiver_if.slave bus
);

    logic               w_byteValid;
    logic [7:0]         w_byteData;
    logic               w_byteDc;
    logic [COORD_W-1:0] w_paramVal;
    logic               w_cmdValid, w_pixelValid, w_frameDone;

    parser_state_t      r_state, w_stateNext;
    logic [2:0]         r_paramIdx, w_paramIdxNext;
    logic [7:0]         r_paramHi, w_paramHiNext;
    logic [7:0]         r_pixHi, w_pixHiNext;
    logic [COORD_W-1:0] r_xs, r_xe, r_ys, r_ye, r_x, r_y;
    logic [COORD_W-1:0] w_xsNext, w_xeNext, w_ysNext, w_yeNext, w_xNext, w_yNext;
    logic [7:0]         r_cmdCode;
    logic [PIXEL_W-1:0] r_lastColor;

    spi_byte_deserializer #(.USE_CS(USE_CS)) u_deser (
        .clk        (clk),
        .rst        (rst),
        .i_tftClk   (bus.tft_clk),
        .i_tftMosi  (bus.tft_mosi),
        .i_tftDc    (bus.tft_dc),
        .i_tftCs    (bus.tft_cs),
        .o_byteValid(w_byteValid),
        .o_byteData (w_byteData),
        .o_byteDc   (w_byteDc)
    );

    assign w_paramVal = COORD_W'({r_paramHi, w_byteData});

    always_comb begin
        w_stateNext    = r_state;
        w_paramIdxNext = r_paramIdx;
        w_paramHiNext  = r_paramHi;
        w_pixHiNext    = r_pixHi;
        w_xsNext       = r_xs;
        w_xeNext       = r_xe;
        w_ysNext       = r_ys;
        w_yeNext       = r_ye;
        w_xNext        = r_x;
        w_yNext        = r_y;
        w_cmdValid     = 1'b0;
        w_pixelValid   = 1'b0;
        w_frameDone    = 1'b0;
        if (w_byteValid && !w_byteDc) begin
            w_cmdValid     = 1'b1;
            w_paramIdxNext = 3'd0;
            case (w_byteData)
                CMD_CASET: w_stateNext = ST_CASET;
                CMD_PASET: w_stateNext = ST_PASET;
                CMD_RAMWR: begin
                    w_stateNext = ST_RAMWR_HI;
                    w_xNext     = r_xs;
                    w_yNext     = r_ys;
                end
                default:   w_stateNext = ST_SKIP;
            endcase
        end else if (w_byteValid) begin
            case (r_state)
                ST_CASET, ST_PASET: begin
                    // Parameters past the fourth leave the window untouched.
                    if (r_paramIdx < 3'd4) begin
                        w_paramIdxNext = r_paramIdx + 3'd1;
                        case (r_paramIdx)
                            3'd1: if (r_state == ST_CASET) w_xsNext = w_paramVal;
                                  else w_ysNext = w_paramVal;
                            3'd3: if (r_state == ST_CASET) w_xeNext = w_paramVal;
                                  else w_yeNext = w_paramVal;
                            default: w_paramHiNext = w_byteData;
                        endcase
                    end
                end
                ST_RAMWR_HI: begin
                    w_pixHiNext = w_byteData;
                    w_stateNext = ST_RAMWR_LO;
                end
                ST_RAMWR_LO: begin
                    w_pixelValid = 1'b1;
                    w_frameDone  = (r_x == r_xe) && (r_y == r_ye);
                    w_stateNext  = ST_RAMWR_HI;
                    if (r_x == r_xe) begin
                        w_xNext = r_xs;
                        w_yNext = (r_y == r_ye) ? r_ys : r_y + COORD_W'(1);
                    end else begin
                        w_xNext = r_x + COORD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_paramIdx  <= 3'd0;
            r_paramHi   <= 8'd0;
            r_pixHi     <= 8'd0;
            r_xs        <= '0;
            r_xe        <= COORD_W'(WIDTH - 1);
            r_ys        <= '0;
            r_ye        <= COORD_W'(HEIGHT - 1);
            r_x         <= '0;
            r_y         <= '0;
            r_cmdCode   <= 8'd0;
            r_lastColor <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_paramIdx <= w_paramIdxNext;
            r_paramHi  <= w_paramHiNext;
            r_pixHi    <= w_pixHiNext;
            r_xs       <= w_xsNext;
            r_xe       <= w_xeNext;
            r_ys       <= w_ysNext;
            r_ye       <= w_yeNext;
            r_x        <= w_xNext;
            r_y        <= w_yNext;
            if (w_cmdValid)   r_cmdCode   <= w_byteData;
            if (w_pixelValid) r_lastColor <= {r_pixHi, w_byteData};
        end
    end

    assign bus.byte_valid  = w_byteValid;
    assign bus.byte_data   = w_byteData;
    assign bus.byte_dc     = w_byteDc;
    assign bus.cmd_valid   = w_cmdValid;
    assign bus.cmd_code    = w_cmdValid ? w_byteData : r_cmdCode;
    assign bus.pixel_valid = w_pixelValid;
    assign bus.pixel_x     = r_x;
    assign bus.pixel_y     = r_y;
    assign bus.pixel_color = w_pixelValid ? {r_pixHi, w_byteData} : r_lastColor;
    assign bus.frame_done  = w_frameDone;

endmodule
